// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry and the
// Gray-code helpers used by both the write-side and read-side controllers.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  // Pointers carry one wrap bit above the RAM address: PTR_W = ADDR_WIDTH + 1.
  localparam int DEFAULT_PTR_W      = DEFAULT_ADDR_WIDTH + 1;

  // Helpers operate on a wide container. Zero-extended inputs convert
  // correctly at any narrower width, so callers size-cast in and out.
  localparam int MAX_PTR_W = 32;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at
// and above it. Shared by the write and read controllers for level logic.
module fifo_gray2bin #(
  parameter int W = fifo_pkg::DEFAULT_PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/wr_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO; everything
// here runs in the write clock domain.
module wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   wlevel
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] rptr_full;
  logic             wen;

  fifo_gray2bin #(.W(PTR_W)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  always_comb begin
    // NOTE: every signal driven here is assigned on every pass through the
    // block, so no storage (latch) is implied.
    wen        = winc & ~full;
    wbin_next  = wbin + PTR_W'(wen);
    wgray_next = PTR_W'(bin2gray(MAX_PTR_W'(wbin_next)));
    level_next = wbin_next - rbin_s;
    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray form that is the read pointer with its top two bits inverted.
    rptr_full  = {~wq2_rptr[ADDR_WIDTH -: 2], wq2_rptr[ADDR_WIDTH-2:0]};
  end

  // wptr comes straight from a flop so it is glitch-free for synchronisation.
  always_ff @(posedge wclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (wrst) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      wlevel      <= '0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      full        <= (wgray_next == rptr_full);
      almost_full <= (level_next >= PTR_W'(AFULL_THRESH));
      overflow    <= overflow | (winc & full);
      wlevel      <= level_next;
    end
  end

  assign waddr = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_wr_ctrl.sv
// Self-checking bench for wr_ctrl: an occupancy-count model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_wr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int THR   = 12;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          winc = 1'b0;
  logic [AW:0]   wq2_rptr = '0;
  logic [AW:0]   wptr;
  logic [AW-1:0] waddr;
  logic          full, almost_full, overflow;
  logic [AW:0]   wlevel;

  int checks   = 0;
  int failures = 0;

  // Model: total accepted writes and total reads released by the read side.
  int wr_count = 0;
  int rd_count = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;
  int m_level = 0;
  bit model_valid = 0;

  wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .wptr        (wptr),
    .waddr       (waddr),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .wlevel      (wlevel)
  );

  always #5 wclk = ~wclk;

  function automatic logic [AW:0] to_gray(input int n);
    int m;
    m = n % (2 * DEPTH);
    return (AW + 1)'(m ^ (m >> 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge.
  task automatic step(input logic rst_i, input logic inc_i);
    wrst     = rst_i;
    winc     = inc_i;
    wq2_rptr = to_gray(rd_count);
    @(posedge wclk);
    if (rst_i) begin
      wr_count = 0;
      m_full   = 0;
      m_afull  = 0;
      m_ovf    = 0;
      m_level  = 0;
    end else begin
      if (inc_i && m_full) m_ovf = 1;
      if (inc_i && !m_full) wr_count++;
      m_level = wr_count - rd_count;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= THR);
    end
    model_valid = 1;
    #1;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge wclk) begin
    if (model_valid) begin
      check("wptr",        32'(wptr),        32'(to_gray(wr_count)));
      check("waddr",       32'(waddr),       32'(wr_count % DEPTH));
      check("full",        32'(full),        32'(m_full));
      check("almost_full", 32'(almost_full), 32'(m_afull));
      check("overflow",    32'(overflow),    32'(m_ovf));
      check("wlevel",      32'(wlevel),      32'(m_level));
    end
  end

  initial begin
    // 1: reset held with winc asserted
    rd_count = 0;
    repeat (3) step(1'b1, 1'b1);
    check("rst_wptr",  32'(wptr),     32'h0);
    check("rst_waddr", 32'(waddr),    32'h0);
    check("rst_full",  32'(full),     32'h0);
    check("rst_ovf",   32'(overflow), 32'h0);
    check("rst_level", 32'(wlevel),   32'h0);

    // 2: fill with read pointer parked at 0
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_waddr", 32'(waddr), 32'(i));
      step(1'b0, 1'b1);
    end
    check("fill_wptr",  32'(wptr),   32'b11000);
    check("fill_full",  32'(full),   32'h1);
    check("fill_level", 32'(wlevel), 32'd16);
    check("fill_waddr_wrap", 32'(waddr), 32'h0);

    // 3: writes while full are rejected and overflow sticks
    repeat (2) step(1'b0, 1'b1);
    check("ovf_wptr", 32'(wptr),     32'b11000);
    check("ovf_set",  32'(overflow), 32'h1);
    step(1'b0, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // 4: read side releases one slot
    rd_count = 1;
    step(1'b0, 1'b0);
    check("rel_full",  32'(full),   32'h0);
    check("rel_level", 32'(wlevel), 32'd15);
    step(1'b0, 1'b1);
    check("refill_full", 32'(full), 32'h1);
    check("refill_wptr", 32'(wptr), 32'b11001);

    // 5: reset while full with winc high, then almost_full threshold
    rd_count = 0;
    step(1'b1, 1'b1);
    check("rst2_ovf",  32'(overflow), 32'h0);
    check("rst2_full", 32'(full),     32'h0);
    repeat (11) step(1'b0, 1'b1);
    check("af11_flag",  32'(almost_full), 32'h0);
    check("af11_level", 32'(wlevel),      32'd11);
    step(1'b0, 1'b1);
    check("af12_flag",  32'(almost_full), 32'h1);
    check("af12_level", 32'(wlevel),      32'd12);

    // 6: preload with reads tracking writes, then fill across the wrap
    rd_count = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_count = wr_count;
      step(1'b0, 1'b1);
    end
    rd_count = DEPTH;
    step(1'b0, 1'b0);
    check("pre_wptr",  32'(wptr),   32'b11000);
    check("pre_level", 32'(wlevel), 32'h0);
    check("pre_full",  32'(full),   32'h0);
    repeat (DEPTH) step(1'b0, 1'b1);
    check("wrap_wptr",  32'(wptr),   32'b00000);
    check("wrap_full",  32'(full),   32'h1);
    check("wrap_level", 32'(wlevel), 32'd16);

    // Write while full in the same cycle a read is released: still rejected
    rd_count = DEPTH + 1;
    step(1'b0, 1'b1);
    check("race_wptr",  32'(wptr),     32'b00000);
    check("race_level", 32'(wlevel),   32'd15);
    check("race_full",  32'(full),     32'h0);
    check("race_ovf",   32'(overflow), 32'h1);

    step(1'b0, 1'b0);
    @(negedge wclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
